// File: rtl/task_4_pkg.sv
// task_4_pkg: shared types, default sizes and width helper for the task 4 datapath.
`default_nettype none

package task_4_pkg;

    typedef enum logic [1:0] {
        s_IDLE    = 2'd0,
        s_COLLECT = 2'd1,
        s_SEND    = 2'd2,
        s_DONE    = 2'd3
    } task_output_enum;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_NUM_WORDS  = 243;
    localparam int DEFAULT_FIFO_DEPTH = 256;

    // One extra bit so a frame of exactly 'depth' words does not wrap.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/task_4_out_fifo.sv
// task_4_out_fifo: synchronous FIFO, registered read data (latency 1), non-destructive on full/empty.
`default_nettype none

module task_4_out_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  sclr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_write;
    logic                  do_read;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_write = wr_en && !full && !sclr;
    assign do_read  = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_read) begin
                dout   <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/task_4_out.sv
// task_4_out: collects core result words into a FIFO and replays the frame as an AXI-Stream master.
// Optional frame length check enabled by defining TASK_4_OUT_LEN_CHECK_EN (adds o_len_err).
`default_nettype none

module task_4_out
    import task_4_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_WORDS  = DEFAULT_NUM_WORDS,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_enb,
    input  logic                  i_last,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    output logic                  o_tlast,
    input  logic                  i_tready,
    output logic                  o_output_last,
    output logic                  o_busy,
`ifdef TASK_4_OUT_LEN_CHECK_EN
    output logic                  o_overflow,
    output logic                  o_len_err
`else
    output logic                  o_overflow
`endif
);

    // Never size the buffer below one nominal frame, whatever FIFO_DEPTH says.
    localparam int DEPTH = (FIFO_DEPTH >= NUM_WORDS) ? FIFO_DEPTH : (1 << $clog2(NUM_WORDS));
    localparam int CW    = count_width(DEPTH);

    task_output_enum state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_inc;
    logic [CW-1:0]   remaining;
    logic [CW-1:0]   remaining_after;
    logic            valid;
    logic            last_beat;
    logic            done_pulse;
    logic            busy;
    logic            overflow;
    logic            collecting;
    logic            accept;
    logic            fifo_wr;
    logic            fifo_rd;
    logic            fifo_empty;
    logic            fifo_full;
    logic [DATA_WIDTH-1:0] fifo_dout;
`ifdef TASK_4_OUT_LEN_CHECK_EN
    logic            len_err;
`endif

    assign collecting      = (state == s_IDLE) || (state == s_COLLECT);
    assign accept          = valid && i_tready;
    assign count_inc       = count + CW'(1);
    assign remaining_after = remaining - CW'(accept);
    assign fifo_wr         = i_enb && collecting && !fifo_full;
    // The FIFO read register is the prefetch stage: refill it whenever it is empty or being drained.
    assign fifo_rd         = (state == s_SEND) && !fifo_empty && (!valid || accept);

    task_4_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .sclr  (i_rst),
        .wr_en (fifo_wr),
        .din   (i_data),
        .rd_en (fifo_rd),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= s_IDLE;
            count      <= '0;
            remaining  <= '0;
            valid      <= 1'b0;
            last_beat  <= 1'b0;
            done_pulse <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
`ifdef TASK_4_OUT_LEN_CHECK_EN
            len_err    <= 1'b0;
`endif
        end else begin
            done_pulse <= 1'b0;
            if (i_enb && (!collecting || fifo_full)) begin
                overflow <= 1'b1;
            end

            case (state)
                s_IDLE: begin
                    if (i_enb) begin
                        count <= CW'(1);
                        busy  <= 1'b1;
                        if (i_last) begin
                            remaining <= CW'(1);
                            state     <= s_SEND;
                        end else begin
                            state <= s_COLLECT;
                        end
                    end
                end

                s_COLLECT: begin
                    if (i_enb) begin
                        if (!fifo_full) begin
                            count <= count_inc;
                        end
                        if (i_last) begin
                            remaining <= fifo_full ? count : count_inc;
                            state     <= s_SEND;
                        end
                    end
                end

                s_SEND: begin
                    if (fifo_rd) begin
                        valid     <= 1'b1;
                        last_beat <= (remaining_after == CW'(1));
                    end else if (accept) begin
                        valid     <= 1'b0;
                        last_beat <= 1'b0;
                    end
                    if (accept) begin
                        remaining <= remaining_after;
                        if (last_beat) begin
                            state      <= s_DONE;
                            done_pulse <= 1'b1;
                        end
                    end
                end

                s_DONE: begin
`ifdef TASK_4_OUT_LEN_CHECK_EN
                    if (count != CW'(NUM_WORDS)) begin
                        len_err <= 1'b1;
                    end
`endif
                    count <= '0;
                    busy  <= 1'b0;
                    state <= s_IDLE;
                end

                default: begin
                    state <= s_IDLE;
                end
            endcase
        end
    end

    assign o_tdata       = fifo_dout;
    assign o_tvalid      = valid;
    assign o_tlast       = last_beat;
    assign o_output_last = done_pulse;
    assign o_busy        = busy;
    assign o_overflow    = overflow;
`ifdef TASK_4_OUT_LEN_CHECK_EN
    assign o_len_err     = len_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_task_4_out.sv
// tb_task_4_out: scoreboard bench for task_4_out.
`default_nettype none

module tb_task_4_out;

    localparam int DW    = 8;
    localparam int NW    = 243;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic [DW-1:0] data   = '0;
    logic          enb    = 1'b0;
    logic          last   = 1'b0;
    logic          tready = 1'b0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          output_last;
    logic          busy;
    logic          overflow;
`ifdef TASK_4_OUT_LEN_CHECK_EN
    logic          len_err;
`endif

    beat_t sb[$];
    int    errors     = 0;
    int    checks     = 0;
    int    mode       = 1;
    int    beats      = 0;
    int    ol_pulses  = 0;
    int    cyc        = 0;
    int    first_acc  = -1;
    int    last_acc   = -1;

    task_4_out #(
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_data        (data),
        .i_enb         (enb),
        .i_last        (last),
        .o_tdata       (tdata),
        .o_tvalid      (tvalid),
        .o_tlast       (tlast),
        .i_tready      (tready),
        .o_output_last (output_last),
        .o_busy        (busy),
`ifdef TASK_4_OUT_LEN_CHECK_EN
        .o_overflow    (overflow),
        .o_len_err     (len_err)
`else
        .o_overflow    (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: 0 = stalled, 1 = always ready, 2 = toggling.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       tready = 1'b0;
                1:       tready = 1'b1;
                default: tready = ~tready;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks AXI-S hold rules.
    initial begin : mon
        logic          prev_hold;
        logic          prev_acc_last;
        logic          prev_ol;
        logic [DW-1:0] pd;
        logic          pl;
        beat_t         e;
        prev_hold     = 1'b0;
        prev_acc_last = 1'b0;
        prev_ol       = 1'b0;
        pd            = '0;
        pl            = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_hold     = 1'b0;
                prev_acc_last = 1'b0;
                prev_ol       = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_tvalid", tvalid, 1);
                    check("hold_tdata", tdata, pd);
                    check("hold_tlast", tlast, pl);
                end
                if (output_last) begin
                    ol_pulses++;
                    check("ol_after_tlast", prev_acc_last, 1);
                    check("ol_single_cycle", prev_ol, 0);
                end
                prev_ol       = output_last;
                prev_acc_last = tvalid && tready && tlast;
                if (tvalid && tready) begin
                    if (sb.size() == 0) begin
                        check("extra_beat", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check("beat_tdata", tdata, e.d);
                        check("beat_tlast", tlast, e.l);
                    end
                    beats++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
                prev_hold = tvalid && !tready;
                pd        = tdata;
                pl        = tlast;
            end
        end
    end

    task automatic send_frame(input int n, input bit with_last, input int base);
        int stored;
        beat_t b;
        stored = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            enb  = 1'b1;
            data = DW'(base + i);
            last = with_last && (i == n - 1);
            if (i < stored) begin
                b.d = DW'(base + i);
                b.l = with_last && (i == stored - 1);
                sb.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        enb  = 1'b0;
        last = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        int n;
        start = ol_pulses;
        n     = 0;
        while (ol_pulses == start && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", ol_pulses - start, 1);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst  = 1'b1;
        enb  = 1'b0;
        last = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (beats < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("beats_reached", beats >= target, 1);
    endtask

    initial begin
        int pulses_before;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_output_last", output_last, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full nominal frame, ready always high: back-to-back beats
        mode = 1; beats = 0; first_acc = -1;
        send_frame(NW, 1'b1, 0);
        check("busy_in_frame", busy, 1);
        wait_done(2000);
        check("t1_beats", beats, NW);
        check("t1_back_to_back", last_acc - first_acc, NW - 1);
        check("t1_overflow", overflow, 0);
        @(negedge clk);
        check("t1_idle_busy", busy, 0);

        // Same frame, ready toggling
        mode = 2; beats = 0;
        send_frame(NW, 1'b1, 0);
        wait_done(3000);
        check("t2_beats", beats, NW);

        // Single-word frame latency
        mode = 1; beats = 0;
        @(posedge clk);
        #1;
        enb = 1'b1; last = 1'b1; data = 8'hA5;
        sb.push_back('{d: 8'hA5, l: 1'b1});
        @(posedge clk);
        #1;
        enb = 1'b0; last = 1'b0;
        @(negedge clk);
        check("t3_c1_tvalid", tvalid, 0);
        @(negedge clk);
        check("t3_c2_tvalid", tvalid, 1);
        check("t3_c2_tlast", tlast, 1);
        check("t3_c2_tdata", tdata, 8'hA5);
        wait_done(50);
        check("t3_beats", beats, 1);

        // Overflow: 257 words into 256 entries
        beats = 0;
        send_frame(DEPTH + 1, 1'b1, 0);
        wait_done(2000);
        check("t4_overflow", overflow, 1);
        check("t4_beats", beats, DEPTH);

        // Write during send sets overflow and adds no beat
        do_reset();
        check("t4b_ovf_clear", overflow, 0);
        mode = 0; beats = 0;
        send_frame(5, 1'b1, 8'h30);
        @(posedge clk);
        #1;
        enb = 1'b1; data = 8'hEE;
        @(posedge clk);
        #1;
        enb = 1'b0;
        @(negedge clk);
        check("t4b_overflow", overflow, 1);
        mode = 1;
        wait_done(200);
        check("t4b_beats", beats, 5);

        // Reset mid-collect
        do_reset();
        send_frame(100, 1'b0, 0);
        check("t5_busy_collect", busy, 1);
        pulses_before = ol_pulses;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5a_tvalid", tvalid, 0);
        check("t5a_busy", busy, 0);
        check("t5a_output_last", output_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();

        // Reset mid-send
        beats = 0;
        send_frame(NW, 1'b1, 0);
        wait_beats(50, 500);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5b_tvalid", tvalid, 0);
        check("t5b_busy", busy, 0);
        check("t5b_output_last", output_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_pulse", ol_pulses - pulses_before, 0);
        beats = 0;
        send_frame(NW, 1'b1, 7);
        wait_done(2000);
        check("t5_beats", beats, NW);

`ifdef TASK_4_OUT_LEN_CHECK_EN
        // Length check
        do_reset();
        check("t6_len_err_rst", len_err, 0);
        send_frame(NW - 1, 1'b1, 0);
        wait_done(2000);
        check("t6_len_err_short", len_err, 1);
        do_reset();
        send_frame(NW, 1'b1, 0);
        wait_done(2000);
        check("t6_len_err_ok", len_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/task_4_out.md
Name: task_4_out

Overview:
Output-side buffer of the task 4 datapath.
- Collects result words from the processing core (data + enable strobe + last marker) into an internal FIFO.
- Replays the frame as an AXI-Stream master (tdata/tvalid/tready/tlast).
- After the last beat is accepted, pulses o_output_last. This pulse drives the input block's i_output_last, which starts the next input frame request.

Parameters:
DATA_WIDTH, 8, width of core result words and of o_tdata
NUM_WORDS, 243, nominal words per frame (used for FIFO sizing and the optional length check)
FIFO_DEPTH, 256, FIFO entries; power of two, >= NUM_WORDS

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high; clock i_clk
i_data  in  DATA_WIDTH  result word from core
i_enb  in  1  i_data valid this cycle (write strobe)
i_last  in  1  qualifies i_enb: this word is the last of the frame
o_tdata  out  DATA_WIDTH  AXI-S data
o_tvalid  out  1  AXI-S valid
o_tlast  out  1  AXI-S last, high on final beat only
i_tready  in  1  AXI-S ready from downstream
o_output_last  out  1  one-cycle pulse after final beat accepted
o_busy  out  1  high in any state other than s_IDLE
o_overflow  out  1  sticky: a write was dropped because FIFO full

Behaviour:
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, o_output_last=0, o_busy=0, o_overflow=0; FIFO flushed; word counter=0; state=s_IDLE.
- Reset mid-frame aborts immediately; no o_output_last pulse is generated.
- State machine:
  - s_IDLE: on i_enb, write the word, counter=1, go to s_COLLECT. If i_last is also high, go directly to s_SEND (single-word frame).
  - s_COLLECT: each i_enb writes a word and increments the counter. On i_enb && i_last, write the word and go to s_SEND. i_last without i_enb is ignored.
  - s_SEND: FIFO read latency is 1. The output stage holds a skid/prefetch register so beats stream back-to-back while i_tready is held high.
    - o_tvalid, o_tdata and o_tlast stay stable until the beat is accepted (tvalid && tready).
    - o_tvalid may not depend on i_tready.
    - o_tlast is high when the remaining-beats count is 1.
    - On acceptance of the tlast beat, go to s_DONE.
  - s_DONE: o_output_last=1 for exactly this cycle, then s_IDLE.
- Latency: with i_enb && i_last sampled at cycle 0, o_tvalid first rises at cycle 2.
  - Steady state with i_tready=1: one beat per cycle.
  - Final accept at cycle k gives o_output_last high at cycle k+1.
- i_enb outside s_IDLE/s_COLLECT is ignored (not written) and sets o_overflow. The core must not produce data before o_output_last.
- FIFO full with i_enb: word dropped, o_overflow set (sticky until reset), frame still terminates on i_last.
- Counter is $clog2(FIFO_DEPTH)+1 bits wide, so a frame of FIFO_DEPTH words cannot wrap it.
- FIFO pointers wrap modulo FIFO_DEPTH.
- i_tready low for arbitrary stretches: output holds, no data loss, no duplicated beats.

Optional Feature:
- Macro TASK_4_OUT_LEN_CHECK_EN.
- Defined:
  - Adds output o_len_err (1 bit, reset 0).
  - In the s_DONE cycle, o_len_err is set high if the beat count sent != NUM_WORDS.
  - o_len_err is sticky until reset.
- Undefined: port and comparator absent; frames of any length 1..FIFO_DEPTH pass silently.

Decomposition:
- Package task_4_pkg holds:
  - state enum task_output_enum {s_IDLE, s_COLLECT, s_SEND, s_DONE};
  - default DATA_WIDTH/NUM_WORDS localparams shared with the input block;
  - function clog2-based count width.
- One sub-module, task_4_out_fifo: synchronous FIFO with
  - ports clk, sclr, wr_en, din, rd_en, dout (read latency 1), empty, full;
  - write-when-full and read-when-empty non-destructive.
- The skid/output register and FSM stay in task_4_out.

Test Plan:
1. 243 words via i_enb (data = index mod 256), last on word 242, i_tready=1 → 243 consecutive beats with tdata 0..242, o_tlast only on beat 242, o_output_last pulse 1 cycle after.
2. Same frame, i_tready toggling 1/0 each cycle → identical data sequence, tdata/tlast stable while tvalid && !tready.
3. Single word 0xA5 with i_enb && i_last in s_IDLE → one beat tdata=0xA5, tvalid and tlast high together at cycle 2, then o_output_last.
4. 257 words into FIFO_DEPTH=256 → o_overflow=1, exactly 256 beats sent, o_output_last still pulses; i_enb during s_SEND also sets o_overflow.
5. i_rst asserted after 100 words collected and after 50 beats sent → next cycle o_tvalid=0, o_busy=0, no o_output_last; following 243-word frame sent correctly.
6. With TASK_4_OUT_LEN_CHECK_EN, send 242-word frame → o_len_err=1 in s_DONE; 243-word frame after reset → o_len_err stays 0.
